prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits upstream of the prelude CPU core and fills its 256-byte instruction memory from a byte stream (serial receiver).
- Holds the core stopped via cpu_run=0 until a framed image has been written and its checksum verified, or until a boot timeout expires with no image.
- Frame format: SYNC byte, LEN byte, LEN data bytes, CSUM byte.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- BOOT_TIMEOUT, 1000000, cycles spent in WAIT_SYNC before running the resident program; 0 means wait forever.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at posedge clk.
- mem_we  out  1  instruction-memory write strobe, one cycle per data byte.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- cpu_run  out  1  1 = core released; 0 = core held (pc frozen at 0).
- load_ok  out  1  sticky; image loaded and checksum matched.
- load_err  out  1  sticky until the next accepted SYNC; checksum mismatch.

Behaviour:
- Reset values:
  - state=WAIT_SYNC.
  - cpu_run, load_ok, load_err, mem_we = 0.
  - mem_addr, mem_wdata = 0.
  - timeout counter = 0.
- rx_ready = !mem_we (combinational from the registered mem_we). It reads 1 out of reset, and at most one byte is accepted per 2 cycles while data is being written.
- States and transitions (all on an accepted byte unless noted):
  - WAIT_SYNC: byte==SYNC_BYTE -> GET_LEN. Other bytes are discarded and do not restart the timer. The timer increments each cycle; when it reaches BOOT_TIMEOUT (BOOT_TIMEOUT!=0) -> RUN with load_ok=0.
  - GET_LEN: latch remaining = (byte==0) ? 256 : byte (9-bit). Clear the checksum accumulator and set the address counter to 0. -> GET_DATA.
  - GET_DATA: on the accepting edge, mem_we<=1, mem_addr<=addr counter, mem_wdata<=byte. Then addr+=1, sum+=byte (mod 256), remaining-=1. When remaining reaches 0 -> GET_CSUM.
  - GET_CSUM: if (sum+byte) mod 256 == 0 -> RUN with load_ok<=1. Otherwise -> ERROR with load_err<=1.
  - ERROR: cpu_run=0. Non-SYNC bytes are discarded. SYNC_BYTE -> GET_LEN with load_err<=0. No timeout applies.
  - RUN: cpu_run=1 (registered, asserted the cycle after entry). All bytes are accepted and discarded, including SYNC. RUN is left only by rst.
- Write latency: mem_we pulses high for exactly one cycle, in the cycle after the byte is accepted. mem_addr and mem_wdata hold their last values when mem_we=0.
- Timeout rules:
  - The timer is only active in WAIT_SYNC before the first accepted SYNC.
  - If SYNC is accepted on the same edge the timer would expire, SYNC wins and the state goes to GET_LEN.
- LEN=0 writes addresses 0..255. The address counter never wraps within a frame.
- Bytes presented while rx_ready=0 are not consumed; the source must hold them.
- rst asserted mid-frame: everything returns immediately to reset values. Partially written memory is not cleared, and the next frame overwrites it.
- Memory is written only in GET_DATA. The loader never reads memory.

Test Plan:
- Reset, then send A5,02,11,22,CD -> mem writes (0,11),(1,22), each mem_we a single-cycle pulse; load_ok=1; cpu_run=1 one cycle after CSUM is accepted.
- Send A5,01,40,00 (bad csum) -> load_err=1, cpu_run=0. Then send A5,01,40,C0 -> load_err clears at SYNC, load_ok=1, cpu_run=1.
- BOOT_TIMEOUT=16, no rx_valid -> cpu_run=1 after 16 cycles plus 1 register cycle, load_ok=0, no mem_we. Repeat with junk bytes 00,FF before the timeout -> same expiry cycle.
- Send A5,00 then bytes 00..FF and CSUM 80 -> 256 writes to addresses 0..255 in order, load_ok=1. Check rx_ready toggles 1,0 at a constant rx_valid.
- Assert rst during GET_DATA after 3 of 5 bytes -> all outputs at reset values the same cycle; a fresh full frame then loads correctly.
- SYNC accepted on the exact expiry cycle (BOOT_TIMEOUT=16) -> state GET_LEN, cpu_run stays 0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: frames SYNC,LEN,DATA*LEN,CSUM from a byte stream into the
// 256-byte instruction memory and releases the core once the image checks.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   rx_data, rx_valid   incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready at posedge
//   mem_we/addr/wdata   instruction-memory write port (one pulse per byte)
//   cpu_run             1 releases the core, 0 holds it with pc at 0
//   load_ok, load_err   image verified / checksum mismatch status
module prog_loader #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned BOOT_TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_run,
   output logic       load_ok,
   output logic       load_err
);

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_LEN,
      GET_DATA,
      GET_CSUM,
      RUN,
      ERROR
   } state_t;

   state_t      state, state_n;
   logic [8:0]  rem, rem_n;
   logic [7:0]  addr, addr_n;
   logic [7:0]  sum, sum_n;
   logic [7:0]  csum;
   logic [31:0] timer, timer_n;
   logic        we_n;
   logic [7:0]  maddr_n, wdata_n;
   logic        ok_n, err_n, run_n;
   logic        accept, is_sync;

   // A write cycle blocks the next byte, so the stream runs at most
   // one byte per two cycles while data is being written.
   assign rx_ready = !mem_we;
   assign accept   = rx_valid && rx_ready;
   assign is_sync  = (rx_data == SYNC_BYTE);
   assign csum     = sum + rx_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_SYNC;
         rem       <= '0;
         addr      <= '0;
         sum       <= '0;
         timer     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         load_ok   <= 1'b0;
         load_err  <= 1'b0;
         cpu_run   <= 1'b0;
      end else begin
         state     <= state_n;
         rem       <= rem_n;
         addr      <= addr_n;
         sum       <= sum_n;
         timer     <= timer_n;
         mem_we    <= we_n;
         mem_addr  <= maddr_n;
         mem_wdata <= wdata_n;
         load_ok   <= ok_n;
         load_err  <= err_n;
         cpu_run   <= run_n;
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      addr_n  = addr;
      sum_n   = sum;
      timer_n = timer;
      we_n    = 1'b0;
      maddr_n = mem_addr;
      wdata_n = mem_wdata;
      ok_n    = load_ok;
      err_n   = load_err;
      // cpu_run trails the RUN state by one register stage.
      run_n   = (state == RUN);

      unique case (state)
         WAIT_SYNC: begin
            if (accept && is_sync) begin
               // SYNC beats a timer expiring on the same edge.
               state_n = GET_LEN;
            end else if (BOOT_TIMEOUT != 0) begin
               timer_n = timer + 32'd1;
               if (timer_n == BOOT_TIMEOUT)
                  state_n = RUN;
            end
         end
         GET_LEN: begin
            if (accept) begin
               rem_n   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
               sum_n   = '0;
               addr_n  = '0;
               state_n = GET_DATA;
            end
         end
         GET_DATA: begin
            if (accept) begin
               we_n    = 1'b1;
               maddr_n = addr;
               wdata_n = rx_data;
               addr_n  = addr + 8'd1;
               sum_n   = csum;
               rem_n   = rem - 9'd1;
               if (rem == 9'd1)
                  state_n = GET_CSUM;
            end
         end
         GET_CSUM: begin
            if (accept) begin
               if (csum == 8'd0) begin
                  ok_n    = 1'b1;
                  state_n = RUN;
               end else begin
                  err_n   = 1'b1;
                  state_n = ERROR;
               end
            end
         end
         ERROR: begin
            if (accept && is_sync) begin
               err_n   = 1'b0;
               state_n = GET_LEN;
            end
         end
         RUN: begin
            // Terminal until reset; bytes are swallowed.
         end
         default: state_n = WAIT_SYNC;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as data
// bytes are driven and matched against the write port as it pulses.
module tb_prog_loader;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_run;
   logic       load_ok;
   logic       load_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] sb[$];
   logic        prev_we;

   prog_loader #(
      .SYNC_BYTE   (8'hA5),
      .BOOT_TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_run  (cpu_run),
      .load_ok  (load_ok),
      .load_err (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write-port monitor: every pulse must match the head of the queue
   // and last exactly one cycle.
   initial prev_we = 1'b0;
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         chk("we_pulse", {31'd0, prev_we}, 0);
         if (sb.size() == 0)
            chk("wr_unexp", {31'd0, mem_we}, 0);
         else
            chk("wr", {16'd0, mem_addr, mem_wdata}, {16'd0, sb.pop_front()});
      end
      prev_we = mem_we;
   end

   task automatic send(input logic [7:0] b, output int waits);
      rx_data  = b;
      rx_valid = 1'b1;
      waits    = 0;
      while (!rx_ready && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      if (!rx_ready) begin
         chk("rx_stall", {31'd0, rx_ready}, 1);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic send_b(input logic [7:0] b);
      int w;
      send(b, w);
   endtask

   task automatic send_wr(input logic [7:0] a, input logic [7:0] b);
      int w;
      sb.push_back({a, b});
      send(b, w);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"},    {31'd0, mem_we},   0);
      chk({tag, "_addr"},  {24'd0, mem_addr}, 0);
      chk({tag, "_wdata"}, {24'd0, mem_wdata},0);
      chk({tag, "_run"},   {31'd0, cpu_run},  0);
      chk({tag, "_ok"},    {31'd0, load_ok},  0);
      chk({tag, "_err"},   {31'd0, load_err}, 0);
      chk({tag, "_rdy"},   {31'd0, rx_ready}, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int bad;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #3;
      chk_reset_vals("rst");

      // Basic two-byte image
      do_reset();
      send_b(8'hA5);
      send_b(8'h02);
      send_wr(8'd0, 8'h11);
      send_wr(8'd1, 8'h22);
      send_b(8'hCD);
      chk("t1_ok", {31'd0, load_ok}, 1);
      chk("t1_run_early", {31'd0, cpu_run}, 0);
      idle(1);
      chk("t1_run", {31'd0, cpu_run}, 1);
      chk("t1_addr_hold", {24'd0, mem_addr}, 8'd1);
      chk("t1_wdata_hold", {24'd0, mem_wdata}, 8'h22);
      // RUN swallows everything, SYNC included
      send_b(8'hA5);
      send_b(8'h01);
      send_b(8'h77);
      idle(3);
      chk("t1_run_stay", {31'd0, cpu_run}, 1);
      chk("t1_ok_stay", {31'd0, load_ok}, 1);
      chk("t1_sb_left", sb.size(), 0);

      // Bad checksum, then recovery
      do_reset();
      send_b(8'hA5);
      send_b(8'h01);
      send_wr(8'd0, 8'h40);
      send_b(8'h00);
      chk("t2_err", {31'd0, load_err}, 1);
      chk("t2_ok0", {31'd0, load_ok}, 0);
      idle(20);
      chk("t2_held", {31'd0, cpu_run}, 0);
      send_b(8'h33);
      chk("t2_err_keep", {31'd0, load_err}, 1);
      send_b(8'hA5);
      chk("t2_err_clr", {31'd0, load_err}, 0);
      send_b(8'h01);
      send_wr(8'd0, 8'h40);
      send_b(8'hC0);
      chk("t2_ok", {31'd0, load_ok}, 1);
      idle(1);
      chk("t2_run", {31'd0, cpu_run}, 1);
      chk("t2_sb_left", sb.size(), 0);

      // Timeout with an idle line
      do_reset();
      idle(16);
      chk("t3_run_16", {31'd0, cpu_run}, 0);
      idle(1);
      chk("t3_run_17", {31'd0, cpu_run}, 1);
      chk("t3_ok", {31'd0, load_ok}, 0);

      // Junk bytes must not restart the timer
      do_reset();
      send_b(8'h00);
      send_b(8'hFF);
      idle(14);
      chk("t3j_run_16", {31'd0, cpu_run}, 0);
      idle(1);
      chk("t3j_run_17", {31'd0, cpu_run}, 1);
      chk("t3j_ok", {31'd0, load_ok}, 0);

      // Full 256-byte image
      do_reset();
      send_b(8'hA5);
      send_b(8'h00);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         sb.push_back({i[7:0], i[7:0]});
         send(i[7:0], w);
         if (i > 0 && w != 1) bad++;
      end
      send(8'h80, w);
      if (w != 1) bad++;
      chk("t4_rdy_toggle", bad, 0);
      chk("t4_ok", {31'd0, load_ok}, 1);
      idle(1);
      chk("t4_run", {31'd0, cpu_run}, 1);
      chk("t4_sb_left", sb.size(), 0);

      // Reset in the middle of data
      do_reset();
      send_b(8'hA5);
      send_b(8'h05);
      send_wr(8'd0, 8'h01);
      send_wr(8'd1, 8'h02);
      rx_data = 8'h03;
      for (int i = 0; i < 4 && !rx_ready; i++) @(negedge clk);
      @(posedge clk);
      #2;
      chk("t5_we_pre", {31'd0, mem_we}, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals("t5");
      rx_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      send_b(8'hA5);
      send_b(8'h02);
      send_wr(8'd0, 8'h11);
      send_wr(8'd1, 8'h22);
      send_b(8'hCD);
      chk("t5_ok", {31'd0, load_ok}, 1);
      idle(1);
      chk("t5_run", {31'd0, cpu_run}, 1);
      chk("t5_sb_left", sb.size(), 0);

      // SYNC on the exact expiry edge wins
      do_reset();
      idle(15);
      send_b(8'hA5);
      idle(4);
      chk("t6_held", {31'd0, cpu_run}, 0);
      send_b(8'h01);
      send_wr(8'd0, 8'h40);
      send_b(8'hC0);
      chk("t6_ok", {31'd0, load_ok}, 1);
      idle(1);
      chk("t6_run", {31'd0, cpu_run}, 1);
      chk("t6_sb_left", sb.size(), 0);

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
